// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// The memory stage drives the request/response interface using these bundles.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         MEM_WORD_BYTES = 4;
    localparam logic [3:0] STROBE_LOAD    = 4'b0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_resp_t;

    // Misaligned or beyond the last word of a RAM with 'depth' words.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] idx;
        idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (idx >= 32'(depth));
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strobe);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < MEM_WORD_BYTES; i++) begin
            if (strobe[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_dmem_ram.sv
// Word-organised data RAM: combinational read, synchronous byte-strobed write.
module data_mem_responder_dmem_ram
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Byte-merged write; the read port still shows the pre-write word this cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= merge_bytes(mem[addr], wdata, wstrb);
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the pipeline data-memory interface: one outstanding request,
// response after LATENCY cycles, store commit and read sampling on entry to RESP.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_strobe,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;
    dmem_resp_t  resp_q, resp_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;

    dmem_req_t   req_in;
    dmem_req_t   req_cur;
    logic        cur_err;
    logic        commit;
    logic        ram_we;
    logic [31:0] ram_rdata;

    assign req_in  = '{addr: req_addr, strobe: req_strobe, wdata: req_wdata};
    // With LATENCY=1 the commit happens straight out of IDLE, so use the live request.
    assign req_cur = (state_q == IDLE) ? req_in : req_q;
    assign cur_err = addr_err(req_cur.addr, DEPTH);
    assign ram_we  = commit && !reset && !cur_err && (req_cur.strobe != STROBE_LOAD);

    data_mem_responder_dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (req_cur.addr[AW+1:2]),
        .wstrb (req_cur.strobe),
        .wdata (req_cur.wdata),
        .rdata (ram_rdata)
    );

    // Next-state, counter and response computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        resp_d       = resp_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        commit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d       = req_in;
                    req_ready_d = 1'b0;
                    if (LAT_M1 == 4'd0) begin
                        commit = 1'b1;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase

        if (commit) begin
            state_d      = RESP;
            cnt_d        = 4'd0;
            resp_valid_d = 1'b1;
            req_ready_d  = 1'b0;
            resp_d.err   = cur_err;
            resp_d.rdata = cur_err ? 32'd0 : ram_rdata;
        end else begin
            resp_d = resp_d;
        end
    end

    // State and registered outputs; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_q        <= '0;
            resp_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            resp_q       <= resp_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_q.rdata;
    assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders with LATENCY 2, 4 and 1 on a shared clock.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 4;
    localparam int LAT2  = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic [3:0]  req_strobe [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    time  hs_time;
    time  prev_hs;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? LAT0 : ((g == 1) ? LAT1 : LAT2);
        data_mem_responder #(
            .DEPTH   (DEPTH),
            .LATENCY (LAT)
        ) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .req_strobe (req_strobe[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : ((k == 1) ? LAT1 : LAT2);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one request on instance k, then score its response.
    task automatic do_req(input int k, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic chk_rd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int hold, input logic rst_in_resp);
        exp_t e;
        int   n;
        @(negedge clk);
        check_val("req_ready_idle", {31'd0, req_ready[k]}, 32'd1);
        req_valid[k]  = 1'b1;
        req_addr[k]   = addr;
        req_strobe[k] = strb;
        req_wdata[k]  = wdata;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.chk_rd = chk_rd;
        e.lat    = lat_of(k);
        sb_q.push_back(e);
        @(posedge clk);
        hs_time = $time;
        #1;
        req_valid[k]  = 1'b0;
        req_addr[k]   = $urandom;
        req_strobe[k] = 4'($urandom);
        req_wdata[k]  = $urandom;
        n = 1;
        @(negedge clk);
        while (!resp_valid[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = sb_q.pop_front();
        check_val("resp_latency", 32'(n), 32'(e.lat));
        check_val("resp_err", {31'd0, resp_err[k]}, {31'd0, e.err});
        check_val("req_ready_busy", {31'd0, req_ready[k]}, 32'd0);
        if (e.chk_rd) begin
            check_val("resp_rdata", resp_rdata[k], e.rdata);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", {31'd0, resp_valid[k]}, 32'd1);
            check_val("hold_rdata", resp_rdata[k], e.rdata);
            check_val("hold_err", {31'd0, resp_err[k]}, {31'd0, e.err});
            check_val("hold_req_ready", {31'd0, req_ready[k]}, 32'd0);
        end
        if (rst_in_resp) begin
            rst[k] = 1'b1;
            @(posedge clk);
            #1 rst[k] = 1'b0;
        end else if (k != 2) begin
            resp_ready[k] = 1'b1;
            @(posedge clk);
            #1 resp_ready[k] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]        = 1'b1;
            req_valid[k]  = 1'b0;
            req_addr[k]   = 32'd0;
            req_strobe[k] = 4'd0;
            req_wdata[k]  = 32'd0;
            resp_ready[k] = (k == 2) ? 1'b1 : 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_val("rst_req_ready", {31'd0, req_ready[k]}, 32'd1);
            check_val("rst_resp_valid", {31'd0, resp_valid[k]}, 32'd0);
            check_val("rst_resp_rdata", resp_rdata[k], 32'd0);
            check_val("rst_resp_err", {31'd0, resp_err[k]}, 32'd0);
        end

        // Instance 0 (LATENCY=2): store/load, byte merge, errors, backpressure.
        do_req(0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 0, 1'b0);
        do_req(0, 32'h10, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        do_req(0, 32'h10, 4'b0101, 32'h11223344, 1'b1, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        do_req(0, 32'h10, 4'h0, 32'h0, 1'b1, 32'hDE22BE44, 1'b0, 0, 1'b0);
        do_req(0, 32'h13, 4'h0, 32'h0, 1'b1, 32'd0, 1'b1, 0, 1'b0);
        do_req(0, 32'(DEPTH * 4), 4'hF, 32'h55555555, 1'b1, 32'd0, 1'b1, 0, 1'b0);
        do_req(0, 32'h10, 4'h0, 32'h0, 1'b1, 32'hDE22BE44, 1'b0, 5, 1'b0);
        do_req(0, 32'((DEPTH - 1) * 4), 4'hF, 32'h0BADF00D, 1'b0, 32'd0, 1'b0, 0, 1'b0);
        do_req(0, 32'((DEPTH - 1) * 4), 4'h0, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 0, 1'b0);
        // Store reaching RESP is committed even if reset drops the response.
        do_req(0, 32'h40, 4'hF, 32'hAABBCCDD, 1'b0, 32'd0, 1'b0, 0, 1'b1);
        @(negedge clk);
        check_val("rst_resp_dropped", {31'd0, resp_valid[0]}, 32'd0);
        do_req(0, 32'h40, 4'h0, 32'h0, 1'b1, 32'hAABBCCDD, 1'b0, 0, 1'b0);

        // Instance 1 (LATENCY=4): reset while a store is in WAIT.
        do_req(1, 32'h20, 4'hF, 32'h12345678, 1'b0, 32'd0, 1'b0, 0, 1'b0);
        do_req(1, 32'h20, 4'h0, 32'h0, 1'b1, 32'h12345678, 1'b0, 0, 1'b0);
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_addr[1]   = 32'h20;
        req_strobe[1] = 4'hF;
        req_wdata[1]  = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk);
        #1 rst[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("wait_rst_no_resp", {31'd0, resp_valid[1]}, 32'd0);
        end
        check_val("wait_rst_req_ready", {31'd0, req_ready[1]}, 32'd1);
        do_req(1, 32'h20, 4'h0, 32'h0, 1'b1, 32'h12345678, 1'b0, 0, 1'b0);

        // Instance 2 (LATENCY=1, resp_ready tied high): back-to-back loads.
        do_req(2, 32'h0, 4'hF, 32'h01020304, 1'b0, 32'd0, 1'b0, 0, 1'b0);
        do_req(2, 32'h0, 4'h0, 32'h0, 1'b1, 32'h01020304, 1'b0, 0, 1'b0);
        prev_hs = hs_time;
        for (int i = 0; i < 2; i++) begin
            do_req(2, 32'h0, 4'h0, 32'h0, 1'b1, 32'h01020304, 1'b0, 0, 1'b0);
            check_val("accept_interval", 32'(hs_time - prev_hs), 32'd20);
            prev_hs = hs_time;
        end
        // Request coinciding with reset is not accepted and never commits.
        @(negedge clk);
        rst[2]        = 1'b1;
        req_valid[2]  = 1'b1;
        req_addr[2]   = 32'h0;
        req_strobe[2] = 4'hF;
        req_wdata[2]  = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        rst[2]       = 1'b0;
        req_valid[2] = 1'b0;
        @(negedge clk);
        check_val("rst_wins_no_resp", {31'd0, resp_valid[2]}, 32'd0);
        do_req(2, 32'h0, 4'h0, 32'h0, 1'b1, 32'h01020304, 1'b0, 0, 1'b0);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
